// File: rtl/sbentsrc_health_pack.sv
// Continuous RCT/APT health tests on raw entropy samples, packing passing samples
// into OUT_WIDTH-bit words on a valid/ready output with a latched alarm.
module sbentsrc_health_pack #(
    parameter int RNG_WIDTH       = 4,
    parameter int OUT_WIDTH       = 32,
    parameter int STARTUP_SAMPLES = 256,
    parameter int RCT_CUTOFF      = 8,
    parameter int APT_WINDOW      = 64,
    parameter int APT_CUTOFF      = 20
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [RNG_WIDTH-1:0] i_rnd,
    input  logic                 i_rnd_valid,
    input  logic                 i_clr_alarm,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_alarm,
    output logic                 o_rct_fail,
    output logic                 o_apt_fail,
    output logic                 o_drop
);
    localparam int NWORD = OUT_WIDTH / RNG_WIDTH;
    localparam int SW    = $clog2(STARTUP_SAMPLES + 1);
    localparam int RW    = $clog2(RCT_CUTOFF + 1);
    localparam int AW    = $clog2(APT_CUTOFF + 1);
    localparam int PW    = $clog2(APT_WINDOW + 1);
    localparam int FW    = $clog2(NWORD + 1);

    typedef enum logic [1:0] {ST_STARTUP, ST_RUN, ST_ALARM} state_t;

    state_t                            state;
    logic [SW-1:0]                     start_cnt;
    logic [RNG_WIDTH-1:0]              prev;
    logic [RNG_WIDTH-1:0]              apt_ref;
    logic [RW-1:0]                     rct_cnt;
    logic [AW-1:0]                     apt_cnt;
    logic [PW-1:0]                     apt_pos;
    logic [NWORD-1:0][RNG_WIDTH-1:0]   pack;
    logic [FW-1:0]                     fill;

    logic                              sample, rct_hit, apt_hit, apt_first, fail;
    logic [RW-1:0]                     rct_next;
    logic [AW-1:0]                     apt_next;
    logic [PW-1:0]                     pos_next;

    logic                              out_free, moved, drop_n, valid_n;
    logic [FW-1:0]                     fill_n;
    logic [NWORD-1:0][RNG_WIDTH-1:0]   pack_n;
    logic [OUT_WIDTH-1:0]              data_n;

    // Health-test evaluation of the sample presented this cycle.
    always_comb begin
        sample    = i_rnd_valid && (state != ST_ALARM);
        apt_first = (apt_pos == '0);
        rct_next  = RW'(1);
        if (rct_cnt != '0 && i_rnd == prev)
            rct_next = (rct_cnt == RW'(RCT_CUTOFF)) ? rct_cnt : rct_cnt + RW'(1);
        rct_hit   = (rct_next == RW'(RCT_CUTOFF));
        apt_next  = apt_cnt;
        if (apt_first)
            apt_next = AW'(1);
        else if (i_rnd == apt_ref && apt_cnt != AW'(APT_CUTOFF))
            apt_next = apt_cnt + AW'(1);
        apt_hit   = (apt_first || i_rnd == apt_ref) && (apt_next == AW'(APT_CUTOFF));
        pos_next  = (apt_pos == PW'(APT_WINDOW - 1)) ? '0 : apt_pos + PW'(1);
        fail      = sample && (rct_hit || apt_hit);
    end

    // Packing: a full buffer parks while the output register is held; it moves
    // out on the accepting cycle so the next sample can start a fresh word.
    always_comb begin
        out_free = !o_valid || i_ready;
        moved    = 1'b0;
        drop_n   = 1'b0;
        fill_n   = fill;
        pack_n   = pack;
        data_n   = o_data;
        valid_n  = o_valid && !i_ready;
        if (fill == FW'(NWORD) && out_free) begin
            data_n  = pack;
            valid_n = 1'b1;
            fill_n  = '0;
            moved   = 1'b1;
        end
        if (sample) begin
            if (fill_n == FW'(NWORD)) begin
                drop_n = 1'b1;
            end else begin
                pack_n = {i_rnd, pack[NWORD-1:1]};
                if (fill_n == FW'(NWORD - 1) && out_free && !moved) begin
                    data_n  = {i_rnd, pack[NWORD-1:1]};
                    valid_n = 1'b1;
                    fill_n  = '0;
                end else begin
                    fill_n = fill_n + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_STARTUP;
            start_cnt  <= '0;
            prev       <= '0;
            apt_ref    <= '0;
            rct_cnt    <= '0;
            apt_cnt    <= '0;
            apt_pos    <= '0;
            pack       <= '0;
            fill       <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_alarm    <= 1'b0;
            o_rct_fail <= 1'b0;
            o_apt_fail <= 1'b0;
            o_drop     <= 1'b0;
        end else begin
            o_drop <= 1'b0;
            case (state)
                ST_ALARM: begin
                    if (i_clr_alarm) begin
                        state      <= ST_STARTUP;
                        start_cnt  <= '0;
                        rct_cnt    <= '0;
                        apt_cnt    <= '0;
                        apt_pos    <= '0;
                        fill       <= '0;
                        o_alarm    <= 1'b0;
                        o_rct_fail <= 1'b0;
                        o_apt_fail <= 1'b0;
                    end
                end
                default: begin
                    if (fail) begin
                        state      <= ST_ALARM;
                        o_alarm    <= 1'b1;
                        o_rct_fail <= rct_hit;
                        o_apt_fail <= apt_hit;
                        o_valid    <= 1'b0;
                        fill       <= '0;
                    end else begin
                        if (sample) begin
                            prev    <= i_rnd;
                            rct_cnt <= rct_next;
                            apt_cnt <= apt_next;
                            apt_pos <= pos_next;
                            if (apt_first)
                                apt_ref <= i_rnd;
                        end
                        if (state == ST_STARTUP) begin
                            if (sample) begin
                                if (start_cnt == SW'(STARTUP_SAMPLES - 1)) begin
                                    state     <= ST_RUN;
                                    start_cnt <= SW'(STARTUP_SAMPLES);
                                end else begin
                                    start_cnt <= start_cnt + SW'(1);
                                end
                            end
                        end else begin
                            pack    <= pack_n;
                            fill    <= fill_n;
                            o_data  <= data_n;
                            o_valid <= valid_n;
                            o_drop  <= drop_n;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sbentsrc_health_pack.sv
// Directed-sequence bench with randomized samples, checked each cycle against a
// queue-based reference model of the health tests and word packing.
module tb_sbentsrc_health_pack;
    logic        clk = 1'b0;
    logic        rst, rnd_valid, clr, rdy;
    logic [3:0]  rnd;
    logic [31:0] data;
    logic        valid, alarm, rct_fail, apt_fail, drop;

    always #5 clk = ~clk;

    sbentsrc_health_pack dut (
        .i_clk(clk), .i_reset(rst), .i_rnd(rnd), .i_rnd_valid(rnd_valid),
        .i_clr_alarm(clr), .o_data(data), .o_valid(valid), .i_ready(rdy),
        .o_alarm(alarm), .o_rct_fail(rct_fail), .o_apt_fail(apt_fail), .o_drop(drop)
    );

    int vec = 0, errs = 0;

    // Reference model: mode 0=startup, 1=run, 2=alarm
    int          mode, nstart, ntested;
    logic [3:0]  runq[$], win[$], bufq[$];
    logic        m_valid, m_alarm, m_rct, m_apt, m_drop;
    logic [31:0] m_data;
    logic [3:0]  last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mode = 0; nstart = 0; ntested = 0;
        runq.delete(); win.delete(); bufq.delete();
        m_alarm = 0; m_rct = 0; m_apt = 0; m_drop = 0;
    endtask

    task automatic move_out();
        for (int i = 0; i < 8; i++) m_data[i*4 +: 4] = bufq[i];
        m_valid = 1;
        bufq.delete();
    endtask

    task automatic model_step(input logic v, input logic [3:0] r, input logic rd,
                              input logic cl, input logic rs);
        int cnt;
        logic rf, af;
        if (rs) begin
            model_clear();
            m_valid = 0; m_data = 0;
            return;
        end
        m_drop = 0;
        if (mode == 2) begin
            if (cl) model_clear();
            return;
        end
        rf = 0; af = 0;
        if (v) begin
            if (runq.size() > 0 && runq[$] != r) runq.delete();
            runq.push_back(r);
            rf = (runq.size() >= 8);
            if (ntested % 64 == 0) win.delete();
            win.push_back(r);
            ntested++;
            cnt = 0;
            foreach (win[i]) if (win[i] == win[0]) cnt++;
            af = (cnt >= 20);
        end
        if (rf || af) begin
            mode = 2; m_alarm = 1; m_rct = rf; m_apt = af;
            m_valid = 0; bufq.delete();
            return;
        end
        if (m_valid && rd) m_valid = 0;
        if (mode == 1) begin
            if (bufq.size() == 8 && !m_valid) move_out();
            if (v) begin
                if (bufq.size() == 8) m_drop = 1;
                else begin
                    bufq.push_back(r);
                    if (bufq.size() == 8 && !m_valid) move_out();
                end
            end
        end else if (v) begin
            nstart++;
            if (nstart == 256) mode = 1;
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] r, input logic rd,
                       input logic cl = 1'b0, input logic rs = 1'b0);
        rnd_valid = v; rnd = r; rdy = rd; clr = cl; rst = rs;
        @(posedge clk);
        model_step(v, r, rd, cl, rs);
        if (v) last = r;
        #1;
        chk("valid", {31'b0, valid}, {31'b0, m_valid});
        chk("data", data, m_data);
        chk("alarm", {31'b0, alarm}, {31'b0, m_alarm});
        chk("rct_fail", {31'b0, rct_fail}, {31'b0, m_rct});
        chk("apt_fail", {31'b0, apt_fail}, {31'b0, m_apt});
        chk("drop", {31'b0, drop}, {31'b0, m_drop});
    endtask

    function automatic logic [3:0] nxt();
        return last + 4'($urandom_range(1, 15));
    endfunction

    initial begin
        int n, drops;
        logic [31:0] held;
        logic [3:0] r;
        rst = 1; rnd_valid = 0; rnd = 0; clr = 0; rdy = 0; last = 0;
        model_clear(); m_valid = 0; m_data = 0;

        cyc(0, 0, 0, 0, 1);
        cyc(1, 4'h3, 1, 0, 1);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_data", data, 32'd0);

        // Startup then first word from cycling symbols
        for (int k = 0; k < 264; k++) begin
            cyc(1, 4'(k % 16), 1);
            if (k == 262) chk("t1_not_yet", {31'b0, valid}, 32'd0);
        end
        chk("t1_valid", {31'b0, valid}, 32'd1);
        chk("t1_data", data, 32'h76543210);

        // Random traffic with random backpressure
        repeat (600) begin
            r = nxt();
            cyc(($urandom % 4) != 0, r, 1'($urandom % 2));
        end
        repeat (3) cyc(0, 0, 1);

        // Backpressure: one word pending, a second fills the buffer, then drops
        n = 0;
        while (!m_valid && n < 40) begin
            cyc(1, nxt(), 0);
            n++;
        end
        chk("t4_pending", {31'b0, valid}, 32'd1);
        held = data;
        drops = 0;
        repeat (16) begin
            cyc(1, nxt(), 0);
            drops += int'(drop);
        end
        chk("t4_drops", drops, 32'd8);
        chk("t4_hold", data, held);
        cyc(0, 0, 1);
        chk("t4_reload", {31'b0, valid}, 32'd1);
        cyc(0, 0, 1);
        chk("t4_drained", {31'b0, valid}, 32'd0);

        // RCT failure
        if (last == 4'h5) cyc(1, 4'h6, 1);
        for (int k = 0; k < 8; k++) begin
            cyc(1, 4'h5, 1);
            if (k == 6) chk("t2_pre", {31'b0, alarm}, 32'd0);
        end
        chk("t2_alarm", {31'b0, alarm}, 32'd1);
        chk("t2_rct", {31'b0, rct_fail}, 32'd1);
        chk("t2_apt", {31'b0, apt_fail}, 32'd0);
        chk("t2_valid", {31'b0, valid}, 32'd0);
        repeat (20) cyc(1, nxt(), 1);
        chk("t2_quiet", {31'b0, valid}, 32'd0);

        // Clear, full restart, then APT failure in the first RUN window
        cyc(0, 0, 1, 1);
        chk("t5_alarm", {31'b0, alarm}, 32'd0);
        chk("t5_rct", {31'b0, rct_fail}, 32'd0);
        for (int k = 0; k < 256; k++) cyc(1, 4'(k % 16), 1);
        chk("t5_nostart", {31'b0, valid}, 32'd0);
        for (int j = 0; j < 39; j++) begin
            r = (j % 2 == 0) ? 4'hA : 4'((11 + (j / 2) % 15) % 16);
            cyc(1, r, 1);
            if (j == 7) chk("t5_word", {31'b0, valid}, 32'd1);
            if (j == 36) chk("t3_pre", {31'b0, apt_fail}, 32'd0);
        end
        chk("t3_apt", {31'b0, apt_fail}, 32'd1);
        chk("t3_rct", {31'b0, rct_fail}, 32'd0);
        chk("t3_alarm", {31'b0, alarm}, 32'd1);

        // Reset in the middle of a word with o_valid high
        cyc(0, 0, 0, 1);
        for (int k = 0; k < 264; k++) cyc(1, 4'(k % 16), 0);
        repeat (3) cyc(1, nxt(), 0);
        chk("t6_pending", {31'b0, valid}, 32'd1);
        cyc(1, 4'h9, 1, 0, 1);
        chk("t6_valid", {31'b0, valid}, 32'd0);
        chk("t6_data", data, 32'd0);
        chk("t6_alarm", {31'b0, alarm}, 32'd0);
        chk("t6_drop", {31'b0, drop}, 32'd0);
        for (int k = 0; k < 264; k++) cyc(1, 4'(k % 16), 1);
        chk("t6_restart", data, 32'h76543210);
        chk("t6_revalid", {31'b0, valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
